// File: rtl/line_pkg.sv
// Shared types and constants for the 3x3 Gaussian line stage.
// The kernel is separable: the same 1-2-1 tap is applied horizontally, then vertically.
package line_pkg;

    localparam int M_DEPTH_DEF  = 11;
    localparam int IMG_W_DEF    = 1920;
    localparam int LINE_NUM_DEF = 12;

    typedef logic [7:0]  pix_t;
    typedef logic [11:0] sum_t;

    localparam sum_t K_EDGE  = 12'd1;
    localparam sum_t K_MID   = 12'd2;
    localparam sum_t K_ROUND = 12'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // 1-2-1 tap; 12 bits holds both the horizontal (<=1020) and full (<=4080) sums
    function automatic sum_t tap121(input sum_t a, input sum_t b, input sum_t c);
        return a * K_EDGE + b * K_MID + c * K_EDGE;
    endfunction

endpackage

// File: rtl/gauss3x3_core.sv
// One channel, one output row: registered horizontal 1-2-1 per input row,
// then registered vertical 1-2-1 with round-half-up division by 16.
module gauss3x3_core
    import line_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_s0_valid,
    input  logic                 i_s1_valid,
    input  logic [2:0][2:0][7:0] i_win,     // [row][col]: row 1 is the centre row, col 0 is left
    output pix_t                 o_pix
);

    logic [2:0][11:0] hsum;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            sum_t hsum_reg;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    hsum_reg <= '0;
                end else if (i_s0_valid) begin
                    hsum_reg <= tap121(sum_t'(i_win[gi][0]), sum_t'(i_win[gi][1]), sum_t'(i_win[gi][2]));
                end
            end

            assign hsum[gi] = hsum_reg;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pix <= '0;
        end else if (i_s1_valid) begin
            o_pix <= pix_t'((tap121(hsum[0], hsum[1], hsum[2]) + K_ROUND) >> 4);
        end
    end

endmodule

// File: rtl/line_gauss3x3.sv
// 3x3 Gaussian over a column of LINE_NUM rows; emits LINE_NUM-2 interior rows
// per column with left/right edge replication and a one-column flush at line end.
module line_gauss3x3
    import line_pkg::*;
#(
    parameter int M_DEPTH  = M_DEPTH_DEF,
    parameter int IMG_W    = IMG_W_DEF,
    parameter int LINE_NUM = LINE_NUM_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_data_valid,
    input  logic [M_DEPTH-1:0]          i_h_count,
    input  logic [M_DEPTH-1:0]          i_v_count,
    input  logic [LINE_NUM-1:0][7:0]    i_r,
    input  logic [LINE_NUM-1:0][7:0]    i_g,
    input  logic [LINE_NUM-1:0][7:0]    i_b,
    output logic                        o_data_valid,
    output logic [M_DEPTH-1:0]          o_h_count,
    output logic [M_DEPTH-1:0]          o_v_count,
    output logic [LINE_NUM-3:0][7:0]    o_r,
    output logic [LINE_NUM-3:0][7:0]    o_g,
    output logic [LINE_NUM-3:0][7:0]    o_b,
    output logic                        o_seq_err
);

    localparam int                 OUT_NUM = LINE_NUM - 2;
    localparam logic [M_DEPTH-1:0] H_LAST  = M_DEPTH'(IMG_W - 1);

    typedef logic [2:0][LINE_NUM-1:0][7:0] col_t;   // [channel][row]

    col_t                    in_col;
    col_t                    lft_reg;
    col_t                    ctr_reg;
    logic [2:0][2:0][LINE_NUM-1:0][7:0] win_reg;    // [col][channel][row]

    state_t                  state_reg, state_next;
    logic [M_DEPTH-1:0]      last_h_reg, last_h_next;
    logic                    pend_reg, pend_next;
    logic                    seq_err_reg, seq_err_next;
    logic [M_DEPTH-1:0]      v_grp_reg;

    logic                    s0_valid_reg, s1_valid_reg;
    logic [M_DEPTH-1:0]      s0_h_reg, s1_h_reg;
    logic [M_DEPTH-1:0]      s0_v_reg, s1_v_reg;

    logic                    do_load, do_shift, do_flush;
    logic                    h_zero, h_succ;
    logic [2:0][OUT_NUM-1:0][7:0] out_pix;

    assign in_col[0] = i_r;
    assign in_col[1] = i_g;
    assign in_col[2] = i_b;

    assign h_zero = (i_h_count == '0);
    assign h_succ = (i_h_count == M_DEPTH'(last_h_reg + 1'b1));

    // A pending flush owns the issue slot this edge; only a fresh h=0 may load alongside it
    always_comb begin
        state_next   = state_reg;
        last_h_next  = last_h_reg;
        pend_next    = 1'b0;
        seq_err_next = seq_err_reg;
        do_load      = 1'b0;
        do_shift     = 1'b0;
        do_flush     = pend_reg;

        if (pend_reg) begin
            state_next = IDLE;
            if (i_data_valid && h_zero) begin
                do_load    = 1'b1;
                state_next = RUN;
            end
        end else if (i_data_valid) begin
            case (state_reg)
                IDLE: begin
                    if (h_zero) begin
                        do_load    = 1'b1;
                        state_next = RUN;
                    end
                end
                default: begin
                    if (h_succ) begin
                        do_shift = 1'b1;
                    end else begin
                        seq_err_next = 1'b1;
                        if (h_zero) begin
                            do_load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            endcase
        end

        if (do_load) begin
            last_h_next = '0;
            pend_next   = (i_h_count == H_LAST);
        end
        if (do_shift) begin
            last_h_next = i_h_count;
            pend_next   = (i_h_count == H_LAST);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            last_h_reg  <= '0;
            pend_reg    <= 1'b0;
            seq_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_h_reg  <= last_h_next;
            pend_reg    <= pend_next;
            seq_err_reg <= seq_err_next;
        end
    end

    assign o_seq_err = seq_err_reg;

    // S0: column history plus the issued window; S1: control alongside the horizontal sums
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lft_reg      <= '0;
            ctr_reg      <= '0;
            win_reg      <= '0;
            v_grp_reg    <= '0;
            s0_valid_reg <= 1'b0;
            s0_h_reg     <= '0;
            s0_v_reg     <= '0;
            s1_valid_reg <= 1'b0;
            s1_h_reg     <= '0;
            s1_v_reg     <= '0;
        end else begin
            s0_valid_reg <= do_shift | do_flush;

            if (do_shift) begin
                win_reg[0] <= lft_reg;
                win_reg[1] <= ctr_reg;
                win_reg[2] <= in_col;
                s0_h_reg   <= i_h_count - 1'b1;
                s0_v_reg   <= v_grp_reg;
            end else if (do_flush) begin
                win_reg[0] <= lft_reg;
                win_reg[1] <= ctr_reg;
                win_reg[2] <= ctr_reg;
                s0_h_reg   <= H_LAST;
                s0_v_reg   <= v_grp_reg;
            end

            if (do_shift) begin
                lft_reg <= ctr_reg;
                ctr_reg <= in_col;
            end else if (do_load) begin
                lft_reg   <= in_col;
                ctr_reg   <= in_col;
                v_grp_reg <= i_v_count + 1'b1;
            end

            s1_valid_reg <= s0_valid_reg;
            if (s0_valid_reg) begin
                s1_h_reg <= s0_h_reg;
                s1_v_reg <= s0_v_reg;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data_valid <= 1'b0;
            o_h_count    <= '0;
            o_v_count    <= '0;
        end else begin
            o_data_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                o_h_count <= s1_h_reg;
                o_v_count <= s1_v_reg;
            end
        end
    end

    genvar gc, gi, gr, gk;
    generate
        for (gc = 0; gc < 3; gc++) begin : g_ch
            for (gi = 0; gi < OUT_NUM; gi++) begin : g_out
                logic [2:0][2:0][7:0] core_win;

                for (gr = 0; gr < 3; gr++) begin : g_tap_row
                    for (gk = 0; gk < 3; gk++) begin : g_tap_col
                        assign core_win[gr][gk] = win_reg[gk][gc][gi + gr];
                    end
                end

                gauss3x3_core u_core (
                    .i_clk      (i_clk),
                    .i_rst_n    (i_rst_n),
                    .i_s0_valid (s0_valid_reg),
                    .i_s1_valid (s1_valid_reg),
                    .i_win      (core_win),
                    .o_pix      (out_pix[gc][gi])
                );
            end
        end
    endgenerate

    assign o_r = out_pix[0];
    assign o_g = out_pix[1];
    assign o_b = out_pix[2];

endmodule

// File: doc/line_gauss3x3.md
Name: line_gauss3x3

Overview:
- Downstream stage of the 12-line buffer.
- Consumes one pixel column per valid cycle: LINE_NUM vertically adjacent RGB pixels, plus h/v counts.
- Applies a 3x3 Gaussian (1-2-1 by 1-2-1, /16) to every interior row of the line group.
- Emits LINE_NUM-2 filtered rows per column, with horizontal edge replication, to the next processing stage.

Parameters:
- M_DEPTH, 11, width of h/v counters.
- IMG_W, 1920, active pixels per line; the valid column index range is 0..IMG_W-1.
- LINE_NUM, 12, input rows per column; LINE_NUM >= 3.

Ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_data_valid  in  1  input column valid.
- i_h_count  in  M_DEPTH  column index of the input column.
- i_v_count  in  M_DEPTH  image row of input row 0.
- i_r  in  [LINE_NUM][8]  red, rows 0..LINE_NUM-1.
- i_g  in  [LINE_NUM][8]  green.
- i_b  in  [LINE_NUM][8]  blue.
- o_data_valid  out  1  output column valid.
- o_h_count  out  M_DEPTH  column index of the output column.
- o_v_count  out  M_DEPTH  image row of output row 0, equal to the group i_v_count + 1.
- o_r  out  [LINE_NUM-2][8]  filtered red; output row j is centred on input row j+1.
- o_g  out  [LINE_NUM-2][8]  filtered green.
- o_b  out  [LINE_NUM-2][8]  filtered blue.
- o_seq_err  out  1  sticky column-sequence error.

Behaviour:
- Reset:
  - Asynchronous on i_rst_n low.
  - Clears all outputs to 0, the window registers, the pipeline valids, the pending-flush flag and o_seq_err.
  - FSM goes to IDLE.
- Arithmetic, per channel and per output row:
  - sum = sum over 3x3 window of w*p, with weights 1,2,1 / 2,4,2 / 1,2,1.
  - sum is 12-bit unsigned (max 4080).
  - out = (sum + 8) >> 4. No saturation is needed.
  - Vertical neighbours always exist, because output rows 1..LINE_NUM-2 are interior to the group.
- Horizontal edges:
  - Left: at h=0, the left column = column 0.
  - Right: at h=IMG_W-1, the right column = column IMG_W-1.
- FSM IDLE:
  - Waits for a valid column with h=0.
  - Loads it as both the left and centre columns and moves to RUN.
  - Valid columns with h!=0 are dropped silently.
- FSM RUN:
  - On a valid column with h = last_h+1, the window (left, centre, incoming) produces output column h-1; left <= centre, centre <= incoming.
  - If h = IMG_W-1, pending_flush is set at the same edge.
- Pending flush:
  - On the edge after pending_flush is set, the window (left, centre, centre) produces output column IMG_W-1, independent of i_data_valid; pending_flush clears.
  - If a valid h=0 column is sampled on that same edge, it loads as a new line start and stays in RUN.
  - Otherwise the FSM goes to IDLE.
- Throughput: at most one output column is issued per edge, so back-to-back line groups run at full rate with no stall.
- Sequence errors:
  - In RUN, a valid column with h not equal to last_h+1 and h!=0 sets o_seq_err; the FSM goes to IDLE and the column is dropped.
  - In RUN, a valid h=0 before IMG_W-1 sets o_seq_err; the partial line is abandoned with no flush, and h=0 loads as a new line start.
  - o_seq_err clears only on reset.
- Pipeline:
  - S0 is the window registers, updated at sampling edge k.
  - S1 holds the horizontal 1-2-1 sums per input row, edge k+1.
  - S2 holds the vertical sum, rounding and output registers, edge k+2.
  - o_data_valid, o_h_count, o_v_count and the pixels are presented together after edge k+2.
  - For the flush column, the issue edge is k+1, so its output appears after edge k+3.
- o_v_count is captured at the h=0 column of each group, plus 1, and carried through the pipeline.
- When o_data_valid=0, the outputs hold their previous values.
- Reset mid-line discards all in-flight columns; no partial output follows reset release.

Decomposition:
- Package line_pkg:
  - IMG_W and LINE_NUM defaults.
  - typedef pix_t (8-bit).
  - typedef sum_t (12-bit).
  - Kernel weights and rounding constant 8.
  - FSM enum {IDLE, RUN}.
- Sub-module gauss3x3_core:
  - Combinational/registered 1-2-1 horizontal then vertical sum plus rounding for one channel and one output row.
  - Instantiated (LINE_NUM-2) x 3 times by a generate loop.

Test Plan:
- Flat field: all pixels 100 over 1920 contiguous columns.
  - Required: 1920 outputs, every value 100, o_h_count 0..1919 in order.
  - First output appears 2 edges after sampling h=1.
- Impulse: input row 5, column 10 = 255, all else 0.
  - Required: o_r[4] at column 10 = 64.
  - o_r[4] at columns 9 and 11 = 32; o_r[3] and o_r[5] at column 10 = 32.
  - Diagonals = 16; everything else 0.
- Edge replication: column 0 = 160 on all rows, other columns 0.
  - Required: output column 0 = 120, column 1 = 40, column 2 = 0.
- Right edge: column 1919 = 160, others 0.
  - Required: output column 1919 = 120, column 1918 = 40.
- Back-to-back groups: a second group's h=0 is sampled on the edge after h=1919.
  - Required: column 1919 of group 1 is emitted, then group 2 is continuous.
  - 3840 outputs total; o_v_count = 1 then 13 (input v = 0, 12).
- Sequence error and reset:
  - h sequence 0..5 then 7 -> o_seq_err=1 and no further outputs until the next h=0.
  - i_rst_n low mid-line -> all outputs 0 immediately; o_seq_err cleared; resumes on h=0.
